// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus for pipe_ctrl.
// Parameters: OPW opcode width, AW register address width, CNTW stall counter width.
// master: drives the ID-stage instruction fields and the EX zero flag, and receives
//         the hazard/control outputs.
// slave : the pipe_ctrl side.
// Signals:
//   id_valid, id_op, id_rs, id_rt, id_rd  instruction currently in ID
//   ex_zero                               ALU zero flag for the instruction in EX
//   stall, flush                          hold IF/ID; squash IF/ID and redirect PC
//   ex_aluop, ex_alusrc                   EX-stage controls
//   mem_write                             MEM-stage control
//   mem_to_reg, wb_wen, wb_waddr          WB-stage controls
//   fwd_a, fwd_b                          EX operand source (00 rf, 01 EX/MEM, 10 MEM/WB)
//   illegal                               one-cycle pulse for an illegal opcode
//   stall_cnt                             saturating count of stall cycles
interface pipe_ctrl_if #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned AW   = 4,
  parameter int unsigned CNTW = 16
);
  logic            id_valid;
  logic [OPW-1:0]  id_op;
  logic [AW-1:0]   id_rs;
  logic [AW-1:0]   id_rt;
  logic [AW-1:0]   id_rd;
  logic            ex_zero;
  logic            stall;
  logic            flush;
  logic [2:0]      ex_aluop;
  logic            ex_alusrc;
  logic            mem_write;
  logic            mem_to_reg;
  logic            wb_wen;
  logic [AW-1:0]   wb_waddr;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            illegal;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output id_valid, id_op, id_rs, id_rt, id_rd, ex_zero,
    input  stall, flush, ex_aluop, ex_alusrc, mem_write, mem_to_reg,
    input  wb_wen, wb_waddr, fwd_a, fwd_b, illegal, stall_cnt
  );

  modport slave (
    input  id_valid, id_op, id_rs, id_rt, id_rd, ex_zero,
    output stall, flush, ex_aluop, ex_alusrc, mem_write, mem_to_reg,
    output wb_wen, wb_waddr, fwd_a, fwd_b, illegal, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipelined decode/control unit for a 5-stage CPU (IF/ID/EX/MEM/WB).
// Decodes the ID opcode, carries the control bundle through ID/EX, EX/MEM and MEM/WB,
// detects RAW / load-use hazards (stall or forward) and squashes the wrong-path
// instruction on a taken BEQ.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pipe_ctrl_if.slave (ID instruction, ex_zero in; control outputs out)
// Build option: define PIPE_CTRL_FWD_EN to enable EX operand forwarding; only load-use
// and the WB same-cycle read then stall. Undefined: no forwarding, stall on any RAW
// dependency on ID/EX, EX/MEM or MEM/WB.
module pipe_ctrl #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned AW   = 4,
  parameter int unsigned CNTW = 16
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);

  // Opcode compared at >= 4 bits so the constants 8..10 are always representable.
  localparam int unsigned OW = (OPW > 4) ? OPW : 4;

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [2:0]    aluop;
    logic          alusrc;
    logic          branch;
    logic          mem_write;
    logic          mem_to_reg;
  } ctrl_t;

  ctrl_t           idex_q, exmem_q, memwb_q;
  logic [AW-1:0]   idex_rs_q, idex_rt_q;
  logic            idex_rs_rd_q, idex_rt_rd_q;
  logic            illegal_q;
  logic [CNTW-1:0] stall_cnt_q;

  ctrl_t         dec;
  logic          dec_legal, dec_rs_rd, dec_rt_rd;
  logic [OW-1:0] op;
  logic          hazard, flush, stall;
  logic [1:0]    fwd_a, fwd_b;

  // Valid writer of a non-zero register r.
  function automatic logic writes_reg(ctrl_t s, logic [AW-1:0] r);
    return s.valid & s.wen & (s.waddr != '0) & (s.waddr == r);
  endfunction

  // ID decode; illegal opcodes and empty slots decode to an all-zero bubble.
  always_comb begin
    op        = OW'(bus.id_op);
    dec       = '0;
    dec_legal = 1'b1;
    dec_rs_rd = 1'b1;
    dec_rt_rd = 1'b0;
    case (op)
      OW'(0), OW'(1), OW'(2), OW'(3), OW'(7): begin
        dec.wen   = 1'b1;
        dec.aluop = op[2:0];
        dec_rt_rd = 1'b1;
      end
      OW'(4): begin
        dec.wen   = 1'b1;
        dec.aluop = op[2:0];
      end
      OW'(5), OW'(6): begin
        dec.wen    = 1'b1;
        dec.aluop  = op[2:0];
        dec.alusrc = 1'b1;
      end
      OW'(8): begin
        dec.wen        = 1'b1;
        dec.alusrc     = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OW'(9): begin
        dec.alusrc    = 1'b1;
        dec.mem_write = 1'b1;
        dec_rt_rd     = 1'b1;
      end
      OW'(10): begin
        dec.aluop  = 3'b001;
        dec.branch = 1'b1;
        dec_rt_rd  = 1'b1;
      end
      default: begin
        dec_legal = 1'b0;
        dec_rs_rd = 1'b0;
      end
    endcase
    dec.waddr = dec.wen ? bus.id_rd : '0;
    dec.valid = bus.id_valid & dec_legal;
    if (!dec.valid) begin
      dec       = '0;
      dec_rs_rd = 1'b0;
      dec_rt_rd = 1'b0;
    end
  end

  // Hazard detection and forwarding, all resolved before the clock edge.
  always_comb begin
    logic dep_ex, dep_wb;
    dep_ex = (dec_rs_rd & writes_reg(idex_q, bus.id_rs)) |
             (dec_rt_rd & writes_reg(idex_q, bus.id_rt));
    dep_wb = (dec_rs_rd & writes_reg(memwb_q, bus.id_rs)) |
             (dec_rt_rd & writes_reg(memwb_q, bus.id_rt));
`ifdef PIPE_CTRL_FWD_EN
    // Load data is not available until MEM/WB; the WB write is not bypassed into ID.
    hazard = (dep_ex & idex_q.mem_to_reg) | dep_wb;
    fwd_a  = 2'b00;
    if (idex_rs_rd_q & writes_reg(exmem_q, idex_rs_q)) begin
      fwd_a = 2'b01;
    end else if (idex_rs_rd_q & writes_reg(memwb_q, idex_rs_q)) begin
      fwd_a = 2'b10;
    end
    fwd_b = 2'b00;
    if (idex_rt_rd_q & writes_reg(exmem_q, idex_rt_q)) begin
      fwd_b = 2'b01;
    end else if (idex_rt_rd_q & writes_reg(memwb_q, idex_rt_q)) begin
      fwd_b = 2'b10;
    end
`else
    begin
      logic dep_mem;
      dep_mem = (dec_rs_rd & writes_reg(exmem_q, bus.id_rs)) |
                (dec_rt_rd & writes_reg(exmem_q, bus.id_rt));
      hazard  = dep_ex | dep_mem | dep_wb;
    end
    fwd_a = 2'b00;
    fwd_b = 2'b00;
`endif
  end

  // A taken branch overrides any stall: the stalled instruction is on the wrong path.
  assign flush = idex_q.valid & idex_q.branch & bus.ex_zero;
  assign stall = hazard & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q       <= '0;
      exmem_q      <= '0;
      memwb_q      <= '0;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_rs_rd_q <= 1'b0;
      idex_rt_rd_q <= 1'b0;
      illegal_q    <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      idex_q       <= (stall | flush) ? '0 : dec;
      idex_rs_q    <= bus.id_rs;
      idex_rt_q    <= bus.id_rt;
      idex_rs_rd_q <= dec_rs_rd & ~(stall | flush);
      idex_rt_rd_q <= dec_rt_rd & ~(stall | flush);
      exmem_q      <= idex_q;
      memwb_q      <= exmem_q;
      illegal_q    <= bus.id_valid & ~dec_legal & ~flush;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNTW'(1);
      end
    end
  end

  assign bus.stall      = stall;
  assign bus.flush      = flush;
  assign bus.ex_aluop   = idex_q.aluop & {3{idex_q.valid}};
  assign bus.ex_alusrc  = idex_q.alusrc & idex_q.valid;
  assign bus.mem_write  = exmem_q.mem_write & exmem_q.valid;
  assign bus.mem_to_reg = memwb_q.mem_to_reg & memwb_q.valid;
  assign bus.wb_wen     = memwb_q.wen & memwb_q.valid;
  assign bus.wb_waddr   = memwb_q.waddr & {AW{memwb_q.valid}};
  assign bus.fwd_a      = fwd_a;
  assign bus.fwd_b      = fwd_b;
  assign bus.illegal    = illegal_q;
  assign bus.stall_cnt  = stall_cnt_q;

  // Stage fields that are carried for completeness but not consumed at WB.
  logic unused_stage_bits;
`ifdef PIPE_CTRL_FWD_EN
  assign unused_stage_bits = ^{memwb_q.aluop, memwb_q.alusrc, memwb_q.branch,
                               memwb_q.mem_write};
`else
  assign unused_stage_bits = ^{memwb_q.aluop, memwb_q.alusrc, memwb_q.branch,
                               memwb_q.mem_write, idex_rs_q, idex_rt_q,
                               idex_rs_rd_q, idex_rt_rd_q};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: decode table, hand-written hazard/flush/reset
// sequences and a randomized run checked against an instruction-level pipeline model.
module tb_pipe_ctrl;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpLw  = 4'd8;
  localparam logic [3:0] OpSw  = 4'd9;
  localparam logic [3:0] OpBeq = 4'd10;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   cyc;

  pipe_ctrl_if #(.OPW(4), .AW(4), .CNTW(16)) bus ();

  pipe_ctrl #(.OPW(4), .AW(4), .CNTW(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction-level reference model ----------------
  typedef struct packed {
    logic       v;
    logic [3:0] op;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] rd;
  } ins_t;

  ins_t        idi, m_ex, m_mem, m_wb;
  logic        m_ill;
  logic [15:0] m_cnt;
  logic        e_flush, e_haz, e_stall;
  logic [1:0]  e_fwd_a, e_fwd_b;

  function automatic bit reads_rt(logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd9, 4'd10};
  endfunction

  function automatic bit dest_is(ins_t w, logic [3:0] r);
    return w.v && (w.op <= 4'd8) && (w.rd != 4'd0) && (w.rd == r);
  endfunction

  function automatic bit reads_from(ins_t c, ins_t w);
    return c.v && (dest_is(w, c.rs) || (reads_rt(c.op) && dest_is(w, c.rt)));
  endfunction

  always_comb begin
    idi = '0;
    if (bus.id_valid && bus.id_op <= 4'd10) begin
      idi.v  = 1'b1;
      idi.op = bus.id_op;
      idi.rs = bus.id_rs;
      idi.rt = bus.id_rt;
      idi.rd = bus.id_rd;
    end
    e_flush = m_ex.v && (m_ex.op == OpBeq) && bus.ex_zero;
    e_fwd_a = 2'b00;
    e_fwd_b = 2'b00;
`ifdef PIPE_CTRL_FWD_EN
    e_haz = ((m_ex.op == OpLw) && reads_from(idi, m_ex)) || reads_from(idi, m_wb);
    if (m_ex.v) begin
      if (dest_is(m_mem, m_ex.rs)) e_fwd_a = 2'b01;
      else if (dest_is(m_wb, m_ex.rs)) e_fwd_a = 2'b10;
      if (reads_rt(m_ex.op)) begin
        if (dest_is(m_mem, m_ex.rt)) e_fwd_b = 2'b01;
        else if (dest_is(m_wb, m_ex.rt)) e_fwd_b = 2'b10;
      end
    end
`else
    e_haz = reads_from(idi, m_ex) || reads_from(idi, m_mem) || reads_from(idi, m_wb);
`endif
    e_stall = e_haz && !e_flush;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex  <= '0;
      m_mem <= '0;
      m_wb  <= '0;
      m_ill <= 1'b0;
      m_cnt <= '0;
    end else begin
      m_wb  <= m_mem;
      m_mem <= m_ex;
      m_ex  <= (e_stall || e_flush) ? '0 : idi;
      m_ill <= bus.id_valid && (bus.id_op > 4'd10) && !e_flush;
      if (e_stall && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic issue(input logic v, input logic [3:0] op, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [3:0] rd, input logic z);
    bus.id_valid = v;
    bus.id_op    = op;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_rd    = rd;
    bus.ex_zero  = z;
  endtask

  task automatic bubble();
    issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bubble();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".stall"},      32'(bus.stall),      0);
    chk({tag, ".flush"},      32'(bus.flush),      0);
    chk({tag, ".ex_aluop"},   32'(bus.ex_aluop),   0);
    chk({tag, ".ex_alusrc"},  32'(bus.ex_alusrc),  0);
    chk({tag, ".mem_write"},  32'(bus.mem_write),  0);
    chk({tag, ".mem_to_reg"}, 32'(bus.mem_to_reg), 0);
    chk({tag, ".wb_wen"},     32'(bus.wb_wen),     0);
    chk({tag, ".wb_waddr"},   32'(bus.wb_waddr),   0);
    chk({tag, ".fwd_a"},      32'(bus.fwd_a),      0);
    chk({tag, ".fwd_b"},      32'(bus.fwd_b),      0);
    chk({tag, ".illegal"},    32'(bus.illegal),    0);
    chk({tag, ".stall_cnt"},  32'(bus.stall_cnt),  0);
  endtask

  task automatic check_vs_model();
    logic [2:0] aluop;
    aluop = 3'd0;
    if (m_ex.v) aluop = (m_ex.op <= 4'd7) ? m_ex.op[2:0] : (m_ex.op == OpBeq) ? 3'd1 : 3'd0;
    chk("rnd.stall",      32'(bus.stall),      32'(e_stall));
    chk("rnd.flush",      32'(bus.flush),      32'(e_flush));
    chk("rnd.ex_aluop",   32'(bus.ex_aluop),   32'(aluop));
    chk("rnd.ex_alusrc",  32'(bus.ex_alusrc),
        32'(m_ex.v && (m_ex.op inside {4'd5, 4'd6, 4'd8, 4'd9})));
    chk("rnd.mem_write",  32'(bus.mem_write),  32'(m_mem.v && m_mem.op == OpSw));
    chk("rnd.mem_to_reg", 32'(bus.mem_to_reg), 32'(m_wb.v && m_wb.op == OpLw));
    chk("rnd.wb_wen",     32'(bus.wb_wen),     32'(m_wb.v && m_wb.op <= 4'd8));
    chk("rnd.wb_waddr",   32'(bus.wb_waddr),   (m_wb.v && m_wb.op <= 4'd8) ? 32'(m_wb.rd) : 0);
    chk("rnd.fwd_a",      32'(bus.fwd_a),      32'(e_fwd_a));
    chk("rnd.fwd_b",      32'(bus.fwd_b),      32'(e_fwd_b));
    chk("rnd.illegal",    32'(bus.illegal),    32'(m_ill));
    chk("rnd.stall_cnt",  32'(bus.stall_cnt),  32'(m_cnt));
  endtask

  // ---------------- decode table ----------------
  typedef struct {
    logic [3:0] op;
    logic [2:0] aluop;
    logic       alusrc;
    logic       mem_write;
    logic       mem_to_reg;
    logic       wen;
    logic       illegal;
  } dec_vec_t;

  dec_vec_t vec[13];

  initial begin
    vec[0]  = '{4'd0,  3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[1]  = '{4'd1,  3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[2]  = '{4'd2,  3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[3]  = '{4'd3,  3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{4'd4,  3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[5]  = '{4'd5,  3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[6]  = '{4'd6,  3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[7]  = '{4'd7,  3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[8]  = '{4'd8,  3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[9]  = '{4'd9,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[10] = '{4'd10, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[11] = '{4'd11, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[12] = '{4'd15, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int  nst;
    bit  done;
    int  add_ex;
    bit  hold;
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bubble();
    #2;
    check_all_zero("reset");
    apply_reset();
    mid();
    check_all_zero("post_reset");

    // Decode table: one instruction into an empty pipeline, followed through each stage.
    for (int i = 0; i < 13; i++) begin
      issue(1'b1, vec[i].op, 4'd1, 4'd2, 4'd3, 1'b0);
      nxt();
      bubble();
      mid();
      chk($sformatf("dec%0d.ex_aluop", vec[i].op),  32'(bus.ex_aluop),  32'(vec[i].aluop));
      chk($sformatf("dec%0d.ex_alusrc", vec[i].op), 32'(bus.ex_alusrc), 32'(vec[i].alusrc));
      chk($sformatf("dec%0d.illegal", vec[i].op),   32'(bus.illegal),   32'(vec[i].illegal));
      nxt();
      mid();
      chk($sformatf("dec%0d.mem_write", vec[i].op), 32'(bus.mem_write), 32'(vec[i].mem_write));
      chk($sformatf("dec%0d.illegal_off", vec[i].op), 32'(bus.illegal), 0);
      nxt();
      mid();
      chk($sformatf("dec%0d.wb_wen", vec[i].op),     32'(bus.wb_wen),     32'(vec[i].wen));
      chk($sformatf("dec%0d.mem_to_reg", vec[i].op), 32'(bus.mem_to_reg), 32'(vec[i].mem_to_reg));
      chk($sformatf("dec%0d.wb_waddr", vec[i].op),   32'(bus.wb_waddr),
          vec[i].wen ? 32'd3 : 32'd0);
      nxt();
    end

    // Asynchronous reset in mid-stream, no clock edge needed.
    apply_reset();
    issue(1'b1, OpAdd, 4'd1, 4'd2, 4'd3, 1'b0);
    nxt();
    issue(1'b1, OpSub, 4'd3, 4'd1, 4'd4, 1'b0);
    nxt();
    nxt();
    mid();
    chk("t1.wb_wen_before", 32'(bus.wb_wen), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t1.async_reset");
    apply_reset();

`ifdef PIPE_CTRL_FWD_EN
    // ADD r3,r1,r2 ; SUB r4,r3,r1 -> EX/MEM forward, no stall.
    issue(1'b1, OpAdd, 4'd1, 4'd2, 4'd3, 1'b0);
    nxt();
    issue(1'b1, OpSub, 4'd3, 4'd1, 4'd4, 1'b0);
    mid();
    chk("t3.stall", 32'(bus.stall), 0);
    nxt();
    bubble();
    mid();
    chk("t3.ex_aluop", 32'(bus.ex_aluop), 1);
    chk("t3.fwd_a", 32'(bus.fwd_a), 1);
    chk("t3.fwd_b", 32'(bus.fwd_b), 0);
    chk("t3.stall_cnt", 32'(bus.stall_cnt), 0);
    nxt();
    nxt();
    nxt();

    // LW r5 ; ADD r6,r5,r1 -> one load-use bubble, then MEM/WB forward.
    apply_reset();
    issue(1'b1, OpLw, 4'd1, 4'd0, 4'd5, 1'b0);
    nxt();
    issue(1'b1, OpAdd, 4'd5, 4'd1, 4'd6, 1'b0);
    mid();
    chk("t4.stall_first", 32'(bus.stall), 1);
    nxt();
    mid();
    chk("t4.stall_second", 32'(bus.stall), 0);
    nxt();
    bubble();
    mid();
    chk("t4.fwd_a", 32'(bus.fwd_a), 2);
    chk("t4.fwd_b", 32'(bus.fwd_b), 0);
    chk("t4.mem_to_reg", 32'(bus.mem_to_reg), 1);
    chk("t4.wb_waddr", 32'(bus.wb_waddr), 5);
    chk("t4.stall_cnt", 32'(bus.stall_cnt), 1);
    nxt();
`else
    // ADD r3,r1,r2 ; SUB r4,r3,r1 -> three stall cycles, SUB reaches EX 4 cycles later.
    issue(1'b1, OpAdd, 4'd1, 4'd2, 4'd3, 1'b0);
    nxt();
    add_ex = cyc;
    issue(1'b1, OpSub, 4'd3, 4'd1, 4'd4, 1'b0);
    nst  = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      mid();
      if (bus.stall) nst++;
      else done = 1'b1;
      chk("t2.fwd_a_off", 32'(bus.fwd_a), 0);
      nxt();
    end
    chk("t2.stall_bound", 32'(done), 1);
    bubble();
    mid();
    chk("t2.stall_cycles", 32'(nst), 3);
    chk("t2.stall_cnt", 32'(bus.stall_cnt), 3);
    chk("t2.sub_ex_latency", 32'(cyc - add_ex), 4);
    chk("t2.ex_aluop", 32'(bus.ex_aluop), 1);
    nxt();
`endif

    // Taken BEQ squashes the following SW; not-taken lets it write.
    for (int z = 1; z >= 0; z--) begin
      apply_reset();
      issue(1'b1, OpBeq, 4'd1, 4'd2, 4'd0, 1'b0);
      nxt();
      issue(1'b1, OpSw, 4'd1, 4'd7, 4'd0, 1'(z));
      mid();
      chk($sformatf("t5.z%0d.flush", z), 32'(bus.flush), 32'(z));
      chk($sformatf("t5.z%0d.stall", z), 32'(bus.stall), 0);
      nxt();
      bubble();
      mid();
      chk($sformatf("t5.z%0d.flush_after", z), 32'(bus.flush), 0);
      chk($sformatf("t5.z%0d.ex_alusrc", z), 32'(bus.ex_alusrc), 32'(z == 0));
      nxt();
      mid();
      chk($sformatf("t5.z%0d.mem_write", z), 32'(bus.mem_write), 32'(z == 0));
      nxt();
    end

    // Illegal opcode pulse; r0 writer creates no dependency.
    apply_reset();
    issue(1'b1, 4'd12, 4'd1, 4'd2, 4'd3, 1'b0);
    nxt();
    bubble();
    mid();
    chk("t6.illegal", 32'(bus.illegal), 1);
    chk("t6.ex_aluop", 32'(bus.ex_aluop), 0);
    nxt();
    mid();
    chk("t6.illegal_pulse", 32'(bus.illegal), 0);
    nxt();
    mid();
    chk("t6.wb_wen", 32'(bus.wb_wen), 0);
    issue(1'b1, OpAdd, 4'd1, 4'd2, 4'd0, 1'b0);
    nxt();
    issue(1'b1, OpSub, 4'd0, 4'd1, 4'd4, 1'b0);
    mid();
    chk("t6.r0_stall", 32'(bus.stall), 0);
    nxt();
    bubble();
    mid();
    chk("t6.r0_fwd_a", 32'(bus.fwd_a), 0);
    chk("t6.r0_ex_aluop", 32'(bus.ex_aluop), 1);
    nxt();

    // Randomized run against the model; a stalled instruction is re-presented.
    apply_reset();
    hold = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        issue(1'($urandom_range(0, 99) < 85),
              ($urandom_range(0, 99) < 85) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(11, 15)),
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
      end else begin
        bus.ex_zero = 1'($urandom_range(0, 1));
      end
      mid();
      check_vs_model();
      hold = e_stall;
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
